// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch FSM state encodings and the default reset PC
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
endpackage

// File: rtl/fetch_sequencer_redirect_q.sv
// fetch_sequencer_redirect_q: holds a taken redirect until its delay-slot instruction has been delivered
//  clk, reset      clock, synchronous active-high reset
//  accept          redirect accepted this cycle (redirect && !stall)
//  valid           F slot holds the delay-slot instruction, consumed in the accept cycle
//  deliver         instruction word captured this cycle
//  launch          fetch request launched this cycle
//  redirect_pc     redirect target
//  due, target     the next launch must use target
module fetch_sequencer_redirect_q
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        valid,
  input  logic        deliver,
  input  logic        launch,
  input  logic [31:0] redirect_pc,
  output logic        due,
  output logic [31:0] target
);
  logic        pend_v;
  logic        cnt;
  logic [31:0] pend_pc;
  logic        now;
  // delay slot already sitting in F: target bypasses the queue
  assign now    = accept && valid;
  assign due    = now || (pend_v && !cnt);
  assign target = now ? redirect_pc : pend_pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v  <= 1'b0;
      cnt     <= 1'b0;
      pend_pc <= RESET_PC_DEF;
    end else if (accept) begin
      pend_v  <= !valid;
      cnt     <= !deliver;
      pend_pc <= redirect_pc;
    end else begin
      if (deliver) cnt <= 1'b0;
      if (launch && !cnt) pend_v <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns PC_F and sequences instruction fetch over a req/ack memory port
//  clk, reset            clock, synchronous active-high reset
//  stall                 hazard unit hold of the F/D register
//  redirect, redirect_pc taken jump/branch from D, applied after one delay slot
//  im_req, im_addr       fetch request and word address
//  im_ack, im_rdata      memory response (may arrive in the request cycle)
//  IR_F, PC_F, PC4_F     delivered instruction, its address, address+4
//  valid_F               F holds an unconsumed instruction
//  fetch_err             sticky misaligned-fetch flag, present only with FETCH_ALIGN_CHK_EN
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] IR_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC4_F,
  output logic        valid_F
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic        fetch_err
`endif
);
  fetch_state_t state, state_n;
  logic        held;
  logic        launch;
  logic        misal;
  logic        park;
  logic        deliver;
  logic        due;
  logic [31:0] target;
  logic [31:0] launch_addr;
  logic [31:0] req_addr;
  logic [31:0] next_pc;
  assign valid_F     = state == FULL;
  assign PC4_F       = PC_F + 32'd4;
  // first REQ cycle, or consuming F while launching the next fetch back-to-back
  assign launch      = (state == REQ && !held) || (valid_F && !stall);
  assign launch_addr = due ? target : next_pc;
`ifdef FETCH_ALIGN_CHK_EN
  assign misal   = launch && |launch_addr[1:0];
  assign park    = fetch_err;
  assign im_addr = launch ? launch_addr : req_addr;
  always_ff @(posedge clk) begin
    if (reset) fetch_err <= 1'b0;
    else if (misal) fetch_err <= 1'b1;
  end
`else
  assign misal   = 1'b0;
  assign park    = 1'b0;
  assign im_addr = launch ? launch_addr & ~32'd3 : req_addr;
`endif
  assign im_req  = (launch && !misal) || (state == REQ && held);
  assign deliver = im_req && im_ack;
  fetch_sequencer_redirect_q u_redirect_q (
    .clk         (clk),
    .reset       (reset),
    .accept      (redirect && !stall),
    .valid       (valid_F),
    .deliver     (deliver),
    .launch      (launch && !misal),
    .redirect_pc (redirect_pc),
    .due         (due),
    .target      (target)
  );
  always_comb begin
    state_n = state;
    state_n = misal ? IDLE :
              deliver ? FULL :
              (state == IDLE && !park) ? REQ :
              (valid_F && !stall) ? REQ : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      held     <= 1'b0;
      req_addr <= RESET_PC;
      next_pc  <= RESET_PC;
      IR_F     <= 32'd0;
      PC_F     <= RESET_PC;
    end else begin
      state <= state_n;
      held  <= im_req && !im_ack;
      if (launch) req_addr <= im_addr;
      if (deliver) begin
        IR_F    <= im_rdata;
        PC_F    <= im_addr;
        next_pc <= im_addr + 32'd4;
      end
    end
  end
endmodule
